// File: rtl/mult_share_sched_if.sv
// rtl/mult_share_sched_if.sv - request, response and multiplier handshake bundle for mult_share_sched
interface mult_share_sched_if;
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_ready;
    logic        mult_start;
    logic [7:0]  mult_dataa;
    logic [7:0]  mult_datab;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        resp0_valid;
    logic        resp0_ready;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [15:0] resp_product;
    logic        resp_err;
    logic        busy;
    logic        owner;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  mult_done, mult_product, resp0_ready, resp1_ready,
        output req0_ready, req1_ready, mult_start, mult_dataa, mult_datab,
        output resp0_valid, resp1_valid, resp_product, resp_err, busy, owner
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output mult_done, mult_product, resp0_ready, resp1_ready,
        input  req0_ready, req1_ready, mult_start, mult_dataa, mult_datab,
        input  resp0_valid, resp1_valid, resp_product, resp_err, busy, owner
    );
endinterface

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin scheduler sharing one sequential 8x8 multiplier between two ports
module mult_share_sched #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_a,
    mult_share_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_grant;
    logic        owner_q;
    logic        err_q;
    logic [7:0]  opa_q;
    logic [7:0]  opb_q;
    logic [7:0]  timer_q;
    logic [15:0] prod_q;
    logic        grant;
    logic        req_hs;
    logic        resp_hs;
    logic        timeout;

    // A lone valid port wins outright; contention goes to the port not served last.
    always_comb begin
        grant = ~last_grant;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset_a is high.
    assign bus.req0_ready = !reset_a && (state == IDLE) && !grant && bus.req0_valid;
    assign bus.req1_ready = !reset_a && (state == IDLE) &&  grant && bus.req1_valid;
    assign req_hs         = bus.req0_ready || bus.req1_ready;
    assign resp_hs        = (state == RESP) && (owner_q ? bus.resp1_ready : bus.resp0_ready);
    assign timeout        = (timer_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_hs) state_nx = LAUNCH;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (bus.mult_done || timeout) state_nx = RESP;
            RESP:    if (resp_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
            opa_q      <= 8'd0;
            opb_q      <= 8'd0;
            timer_q    <= 8'd0;
            prod_q     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        opa_q      <= grant ? bus.req1_a : bus.req0_a;
                        opb_q      <= grant ? bus.req1_b : bus.req0_b;
                        owner_q    <= grant;
                        last_grant <= grant;
                    end
                end
                LAUNCH: begin
                    timer_q <= 8'd0;
                end
                WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    // A done coincident with the last allowed cycle still counts as a result.
                    if (bus.mult_done) begin
                        prod_q <= bus.mult_product;
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        prod_q <= 16'd0;
                        err_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mult_start   = (state == LAUNCH);
    assign bus.mult_dataa   = opa_q;
    assign bus.mult_datab   = opb_q;
    assign bus.resp0_valid  = (state == RESP) && !owner_q;
    assign bus.resp1_valid  = (state == RESP) &&  owner_q;
    assign bus.resp_product = prod_q;
    assign bus.resp_err     = err_q;
    assign bus.busy         = (state != IDLE);
    assign bus.owner        = owner_q;
endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - randomized bench for mult_share_sched with a transaction-level reference model
module tb_mult_share_sched;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset_a;
    always #5 clk = ~clk;

    mult_share_sched_if bus ();
    mult_share_sched #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset_a(reset_a), .bus(bus));

    typedef struct {
        bit          port;
        bit          err;
        logic [15:0] p;
    } resp_t;

    int checks = 0;
    int errors = 0;
    resp_t log_q[$];

    bit         m_busy, m_owner, m_last;
    logic [7:0] m_a, m_b;
    int         m_t, m_lat;

    bit         pend [2];
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    bit         auto_req [2];
    int         req_pct;
    int         rr_pct [2];
    int         lat_fix;
    int         spur_pct;
    int         mul_rem;
    logic [15:0] mul_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pick_lat();
        int r;
        if (lat_fix >= 0) return lat_fix;
        r = int'($urandom_range(9));
        if (r == 0) return 0;
        if (r == 1) return T;
        return int'($urandom_range(8, 1));
    endfunction

    function automatic int resp_start();
        return 2 + ((m_lat == 0) ? T : m_lat);
    endfunction

    task automatic apply_reqs();
        bus.req0_valid = pend[0];
        bus.req0_a     = pend[0] ? pa[0] : 8'($urandom);
        bus.req0_b     = pend[0] ? pb[0] : 8'($urandom);
        bus.req1_valid = pend[1];
        bus.req1_a     = pend[1] ? pa[1] : 8'($urandom);
        bus.req1_b     = pend[1] ? pb[1] : 8'($urandom);
    endtask

    task automatic issue(input int p, input logic [7:0] a, input logic [7:0] b);
        pend[p] = 1'b1;
        pa[p]   = a;
        pb[p]   = b;
        apply_reqs();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_start"},  bus.mult_start, 0);
        chk({tag, "_rdy0"},   bus.req0_ready, 0);
        chk({tag, "_rdy1"},   bus.req1_ready, 0);
        chk({tag, "_rv0"},    bus.resp0_valid, 0);
        chk({tag, "_rv1"},    bus.resp1_valid, 0);
        chk({tag, "_prod"},   bus.resp_product, 0);
        chk({tag, "_err"},    bus.resp_err, 0);
        chk({tag, "_owner"},  bus.owner, 0);
        chk({tag, "_dataa"},  bus.mult_dataa, 0);
        chk({tag, "_datab"},  bus.mult_datab, 0);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = 1'b1;
        m_t    = 0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    endtask

    // One clock: compare at negedge, advance the model, then drive the next cycle's inputs.
    task automatic step();
        bit          in_resp, er0, er1, g, nxt_resp;
        logic [15:0] ep;
        @(negedge clk);
        in_resp = m_busy && (m_t >= resp_start());
        if (bus.req0_valid && !bus.req1_valid)      g = 1'b0;
        else if (bus.req1_valid && !bus.req0_valid) g = 1'b1;
        else                                        g = !m_last;
        er0 = !m_busy && bus.req0_valid && (g == 1'b0);
        er1 = !m_busy && bus.req1_valid && (g == 1'b1);
        ep  = m_a * m_b;
        chk("req0_ready", bus.req0_ready, er0);
        chk("req1_ready", bus.req1_ready, er1);
        chk("mult_start", bus.mult_start, m_busy && (m_t == 1));
        chk("busy", bus.busy, m_busy);
        chk("resp0_valid", bus.resp0_valid, in_resp && !m_owner);
        chk("resp1_valid", bus.resp1_valid, in_resp && m_owner);
        if (m_busy) begin
            chk("owner", bus.owner, m_owner);
            chk("mult_dataa", bus.mult_dataa, m_a);
            chk("mult_datab", bus.mult_datab, m_b);
        end
        if (in_resp) begin
            chk("resp_err", bus.resp_err, m_lat == 0);
            chk("resp_product", bus.resp_product, (m_lat == 0) ? 16'd0 : ep);
        end
        if (bus.mult_start) begin
            mul_rem = m_lat;
            mul_p   = bus.mult_dataa * bus.mult_datab;
        end
        if (in_resp && (m_owner ? bus.resp1_ready : bus.resp0_ready)) begin
            log_q.push_back('{port: m_owner, err: bus.resp_err, p: bus.resp_product});
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_t++;
        end else if (er0 || er1) begin
            m_busy  = 1'b1;
            m_owner = er1;
            m_last  = er1;
            m_a     = pa[er1];
            m_b     = pb[er1];
            m_t     = 1;
            m_lat   = pick_lat();
            pend[er1] = 1'b0;
        end

        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && auto_req[p] && (int'($urandom_range(99)) < req_pct)) begin
                pend[p] = 1'b1;
                pa[p]   = 8'($urandom);
                pb[p]   = 8'($urandom);
            end
        end
        apply_reqs();
        bus.resp0_ready  = int'($urandom_range(99)) < rr_pct[0];
        bus.resp1_ready  = int'($urandom_range(99)) < rr_pct[1];
        bus.mult_done    = 1'b0;
        bus.mult_product = 16'($urandom);
        nxt_resp = m_busy && (m_t >= resp_start());
        if (mul_rem > 0) begin
            mul_rem--;
            if (mul_rem == 0) begin
                bus.mult_done    = 1'b1;
                bus.mult_product = mul_p;
            end
        end else if ((!m_busy || nxt_resp) && (int'($urandom_range(99)) < spur_pct)) begin
            bus.mult_done = 1'b1;
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string name, output int used);
        used = 0;
        while (log_q.size() < n && used < budget) begin
            step();
            used++;
        end
        chk(name, log_q.size(), n);
    endtask

    task automatic do_reset();
        reset_a = 1'b1;
        model_reset();
        mul_rem = 0;
        apply_reqs();
        bus.mult_done    = 1'b0;
        bus.mult_product = 16'd0;
        bus.resp0_ready  = 1'b1;
        bus.resp1_ready  = 1'b1;
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_a = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        auto_req[0] = 1'b0;
        auto_req[1] = 1'b0;
        rr_pct[0] = 100;
        rr_pct[1] = 100;
        spur_pct = 0;
        for (int k = 0; k < 300 && (m_busy || pend[0] || pend[1]); k++) step();
        chk("drain_idle", {m_busy, pend[0], pend[1]}, 0);
    endtask

    initial begin
        int used;
        reset_a = 1'b1;
        auto_req[0] = 1'b0;
        auto_req[1] = 1'b0;
        req_pct = 0;
        rr_pct[0] = 100;
        rr_pct[1] = 100;
        lat_fix = 5;
        spur_pct = 0;
        m_lat = 1;
        m_a = 8'd0;
        m_b = 8'd0;
        m_owner = 1'b0;
        do_reset();

        // Single request on port 0
        log_q.delete();
        issue(0, 8'h0F, 8'h0D);
        wait_log(1, 100, "a_done", used);
        chk("a_latency", used, 8);
        if (log_q.size() >= 1) begin
            chk("a_port", log_q[0].port, 0);
            chk("a_prod", log_q[0].p, 16'h00C3);
            chk("a_err", log_q[0].err, 0);
        end

        // Simultaneous requests straight from reset
        do_reset();
        log_q.delete();
        lat_fix = 3;
        issue(0, 8'hFF, 8'hFF);
        issue(1, 8'h02, 8'h03);
        wait_log(2, 100, "b_done", used);
        if (log_q.size() >= 2) begin
            chk("b_port0", log_q[0].port, 0);
            chk("b_prod0", log_q[0].p, 16'hFE01);
            chk("b_port1", log_q[1].port, 1);
            chk("b_prod1", log_q[1].p, 16'h0006);
        end

        // Sustained contention
        log_q.delete();
        auto_req[0] = 1'b1;
        auto_req[1] = 1'b1;
        req_pct = 100;
        wait_log(6, 200, "c_done", used);
        for (int i = 0; i < 6 && i < log_q.size(); i++) chk("c_owner", log_q[i].port, i % 2);
        drain();

        // Timeout, then done coincident with the last allowed cycle
        log_q.delete();
        lat_fix = 0;
        issue(0, 8'h12, 8'h34);
        wait_log(1, 100, "d_done", used);
        chk("d_latency", used, 19);
        lat_fix = T;
        issue(1, 8'h12, 8'h34);
        wait_log(2, 100, "d2_done", used);
        chk("d2_latency", used, 19);
        if (log_q.size() >= 2) begin
            chk("d_err", log_q[0].err, 1);
            chk("d_prod", log_q[0].p, 16'h0000);
            chk("d2_err", log_q[1].err, 0);
            chk("d2_prod", log_q[1].p, 16'h03A8);
        end

        // Response backpressure with spurious done pulses
        log_q.delete();
        lat_fix = 2;
        issue(1, 8'hAB, 8'hCD);
        step();
        issue(0, 8'h11, 8'h22);
        rr_pct[1] = 0;
        spur_pct = 100;
        repeat (30) step();
        chk("e_stalled", log_q.size(), 0);
        rr_pct[1] = 100;
        spur_pct = 0;
        wait_log(2, 100, "e_done", used);
        if (log_q.size() >= 2) begin
            chk("e_port0", log_q[0].port, 1);
            chk("e_prod0", log_q[0].p, 16'h88EF);
            chk("e_port1", log_q[1].port, 0);
            chk("e_prod1", log_q[1].p, 16'h0242);
        end

        // Reset two cycles after the start pulse
        log_q.delete();
        lat_fix = 10;
        issue(1, 8'h05, 8'h07);
        for (int k = 0; k < 20 && !(m_busy && m_t == 3); k++) step();
        chk("f_in_wait", m_busy && (m_t == 3), 1);
        reset_a = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check_zero("f_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reqs();
        @(negedge clk) reset_a = 1'b0;
        @(posedge clk);
        #1;
        repeat (20) step();
        chk("f_no_resp", log_q.size(), 0);
        lat_fix = 2;
        issue(1, 8'h05, 8'h07);
        issue(0, 8'h09, 8'h09);
        wait_log(2, 100, "f_done", used);
        if (log_q.size() >= 2) begin
            chk("f_port0", log_q[0].port, 0);
            chk("f_prod0", log_q[0].p, 16'h0051);
            chk("f_port1", log_q[1].port, 1);
            chk("f_prod1", log_q[1].p, 16'h0023);
        end

        // Randomized traffic
        auto_req[0] = 1'b1;
        auto_req[1] = 1'b1;
        req_pct = 30;
        rr_pct[0] = 70;
        rr_pct[1] = 60;
        lat_fix = -1;
        spur_pct = 20;
        repeat (3000) step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Shares one sequential 8x8 multiplier between two requesters (port 0, port 1).
- Arbitrates round-robin and latches the winner's operands.
- Launches the multiplier with a one-cycle start pulse, waits for done (bounded by a timeout), then returns the 16-bit product to the owning requester over a valid/ready response.
- Sits between the client logic and the multiplier datapath + its control FSM.

Parameters:
- TIMEOUT_CYCLES, 16, max WAIT-state cycles before aborting with error (legal range 2..255).

Ports:
- clk  in  1  system clock, rising edge
- reset_a  in  1  asynchronous reset, active-high
- req0_valid  in  1  port 0 request valid
- req0_a  in  8  port 0 operand A
- req0_b  in  8  port 0 operand B
- req0_ready  out  1  port 0 request accepted when high with req0_valid
- req1_valid  in  1  port 1 request valid
- req1_a  in  8  port 1 operand A
- req1_b  in  8  port 1 operand B
- req1_ready  out  1  port 1 request accepted when high with req1_valid
- mult_start  out  1  one-cycle start pulse to the multiplier
- mult_dataa  out  8  operand A to the multiplier
- mult_datab  out  8  operand B to the multiplier
- mult_done  in  1  multiplier completion
- mult_product  in  16  multiplier result, valid when mult_done=1
- resp0_valid  out  1  response valid to port 0
- resp0_ready  in  1  port 0 accepts response
- resp1_valid  out  1  response valid to port 1
- resp1_ready  in  1  port 1 accepts response
- resp_product  out  16  product for the current response
- resp_err  out  1  response is a timeout abort (resp_product=0)
- busy  out  1  high in any state other than IDLE
- owner  out  1  port currently served (valid when busy)

Behaviour:
- States: IDLE(0), LAUNCH(1), WAIT(2), RESP(3). The state register is the only asynchronously reset element besides the datapath registers.
- Reset (async, while reset_a=1):
  - state=IDLE; last_grant=1, so port 0 wins first.
  - Operand regs, product reg, resp_err, owner, timer are all 0.
  - All outputs 0.
- Reset mid-operation aborts silently: no response, multiplier ignored until the next launch.
- IDLE:
  - grant = the only valid port; if both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && (grant==N) && reqN_valid. Combinational, no dependency on ready inputs.
  - On handshake: latch a/b into the operand regs, owner<=N, last_grant<=N, go to LAUNCH.
  - mult_done is ignored in IDLE.
- LAUNCH (exactly 1 cycle):
  - mult_start=1, timer<=0, go to WAIT.
- Operand hold: mult_dataa/mult_datab are driven from the operand regs and stay stable from LAUNCH until leaving RESP.
- WAIT:
  - mult_start=0; timer increments every cycle.
  - If mult_done=1: product_reg<=mult_product, resp_err<=0, go to RESP.
  - Else if timer==TIMEOUT_CYCLES-1: product_reg<=0, resp_err<=1, go to RESP.
  - If mult_done arrives in the same cycle as the timeout, done wins (normal result).
- RESP:
  - respN_valid=1 for N=owner only.
  - resp_product/resp_err are held stable until respN_ready=1. The handshake cycle returns to IDLE, so a new request can be accepted the cycle after.
  - mult_done in RESP is ignored.
  - Requests arriving during LAUNCH/WAIT/RESP see ready=0 and must hold.
- Latency: handshake at edge T, mult_start high in cycle T+1. Response valid the cycle after mult_done is sampled. Minimum request-to-request turnaround = multiplier latency + 3 cycles.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1.
- Width: product is passed unmodified (16-bit unsigned). No arithmetic in this block; timer width = 8 bits.

Test Plan:
- Single request: req0 a=0x0F b=0x0D, bench multiplier done after 5 cycles -> one mult_start pulse with dataa=0x0F datab=0x0D; resp0_valid with resp_product=0x00C3, resp_err=0; resp1_valid never asserts.
- Simultaneous requests from reset: req0 (0xFF,0xFF) and req1 (0x02,0x03) both valid -> port 0 served first (0xFE01), then port 1 (0x0006); req1_ready stays 0 until port 0's response handshake.
- Sustained contention: both ports valid for 6 transactions -> owner sequence 0,1,0,1,0,1; busy is low exactly one cycle between transactions.
- Timeout: mult_done held 0, TIMEOUT_CYCLES=16 -> after 16 WAIT cycles, resp_err=1 with resp_product=0x0000. Done coincident with the final timeout cycle -> resp_err=0 and the real product.
- Backpressure: resp1_ready held 0 for 10 cycles -> resp1_valid, resp_product and mult_dataa/b all stable; no new ready to either port; a spurious mult_done pulse is ignored.
- Reset mid-WAIT: assert reset_a 2 cycles after mult_start -> all outputs 0 asynchronously, no response after release. The next req1 is served normally with last_grant=1 semantics: port 0 wins if both are valid.
